// File: rtl/gbuff_host_port.sv
// Host-side sequencer: streams A/B into the global buffers, starts the TPU, then drains OUT to m_*.
// Writes happen in the beat's own cycle; each result word costs address+wait cycles and holds until m_ready.
module gbuff_host_port #(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        len_a,
  input  logic [7:0]        len_b,
  input  logic [7:0]        len_o,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WORD_W-1:0] m_data,
  output logic              wr_en_a,
  output logic              wr_en_b,
  output logic [ADDR_W-1:0] index_a,
  output logic [ADDR_W-1:0] index_b,
  output logic [WORD_W-1:0] wdata_a,
  output logic [WORD_W-1:0] wdata_b,
  output logic              wr_en_o,
  output logic [ADDR_W-1:0] index_o,
  input  logic [WORD_W-1:0] rdata_o,
  output logic              tpu_start,
  input  logic              tpu_done,
  output logic              busy,
  output logic              job_done
);

  typedef enum logic [3:0] {
    IDLE, LOAD_A, LOAD_B, START, WAIT_DONE, RD_ADDR, RD_WAIT, RD_OUT, FINISH
  } state_t;

  state_t state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] len_a_q, len_a_d, len_b_q, len_b_d, len_o_q, len_o_d;
  logic [WORD_W-1:0] m_data_q, m_data_d;
  logic [ADDR_W-1:0] idx_a_q, idx_b_q, idx_o_q;
  logic [WORD_W-1:0] wd_a_q, wd_b_q;
  logic [ADDR_W-1:0] cnt_ext;

  assign cnt_ext = ADDR_W'(cnt_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_a_d   = len_a_q;
    len_b_d   = len_b_q;
    len_o_d   = len_o_q;
    m_data_d  = m_data_q;
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    wr_en_a   = 1'b0;
    wr_en_b   = 1'b0;
    tpu_start = 1'b0;
    m_valid   = 1'b0;
    job_done  = 1'b0;
    busy      = 1'b1;
    index_o   = idx_o_q;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          len_a_d = len_a;
          len_b_d = len_b;
          len_o_d = len_o;
          cnt_d   = 8'd0;
          if (len_a != 8'd0)      state_d = LOAD_A;
          else if (len_b != 8'd0) state_d = LOAD_B;
          else                    state_d = START;
        end
      end
      LOAD_A: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_en_a = 1'b1;
          if (cnt_q == len_a_q - 8'd1) begin
            cnt_d   = 8'd0;
            state_d = (len_b_q != 8'd0) ? LOAD_B : START;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      LOAD_B: begin
        s_ready = 1'b1;
        if (s_valid) begin
          wr_en_b = 1'b1;
          if (cnt_q == len_b_q - 8'd1) begin
            cnt_d   = 8'd0;
            state_d = START;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      START: begin
        tpu_start = 1'b1;
        state_d   = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (tpu_done) begin
          cnt_d   = 8'd0;
          state_d = (len_o_q != 8'd0) ? RD_ADDR : FINISH;
        end
      end
      RD_ADDR: begin
        index_o = cnt_ext;
        state_d = RD_WAIT;
      end
      // Buffer OUT returns data one cycle after the address.
      RD_WAIT: begin
        m_data_d = rdata_o;
        state_d  = RD_OUT;
      end
      RD_OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (cnt_q == len_o_q - 8'd1) begin
            cnt_d   = 8'd0;
            state_d = FINISH;
          end else begin
            cnt_d   = cnt_q + 8'd1;
            state_d = RD_ADDR;
          end
        end
      end
      FINISH: begin
        job_done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Index/wdata follow the beat combinationally and otherwise hold the last write.
  assign index_a = wr_en_a ? cnt_ext : idx_a_q;
  assign index_b = wr_en_b ? cnt_ext : idx_b_q;
  assign wdata_a = wr_en_a ? s_data : wd_a_q;
  assign wdata_b = wr_en_b ? s_data : wd_b_q;
  assign wr_en_o = 1'b0;
  assign m_data  = m_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q    <= 8'd0;
      len_a_q  <= 8'd0;
      len_b_q  <= 8'd0;
      len_o_q  <= 8'd0;
      m_data_q <= '0;
      idx_a_q  <= '0;
      idx_b_q  <= '0;
      idx_o_q  <= '0;
      wd_a_q   <= '0;
      wd_b_q   <= '0;
    end else begin
      cnt_q    <= cnt_d;
      len_a_q  <= len_a_d;
      len_b_q  <= len_b_d;
      len_o_q  <= len_o_d;
      m_data_q <= m_data_d;
      idx_a_q  <= index_a;
      idx_b_q  <= index_b;
      idx_o_q  <= index_o;
      wd_a_q   <= wdata_a;
      wd_b_q   <= wdata_b;
    end
  end

endmodule

// File: doc/gbuff_host_port.md
GBUFF_HOST_PORT -- requirements
Module: gbuff_host_port

Interface
REQ-001 SHALL have parameter WORD_W, default 32, data word width matching the global buffer data ports.
REQ-002 SHALL have parameter ADDR_W, default 32, buffer index width matching the global buffer index ports.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports cmd_valid input 1, cmd_ready output 1, len_a/len_b/len_o input 8 each: job handshake and word counts for buffers A, B and OUT.
REQ-006 SHALL have ports s_valid input 1, s_ready output 1, s_data input WORD_W: host load stream.
REQ-007 SHALL have ports m_valid output 1, m_ready input 1, m_data output WORD_W: result stream.
REQ-008 SHALL have ports wr_en_a/wr_en_b output 1, index_a/index_b output ADDR_W, wdata_a/wdata_b output WORD_W: write side of buffers A and B.
REQ-009 SHALL have ports wr_en_o output 1, index_o output ADDR_W, rdata_o input WORD_W: read side of buffer OUT.
REQ-010 SHALL have ports tpu_start output 1, tpu_done input 1, busy output 1, job_done output 1.

Function
REQ-011 SHALL implement states IDLE, LOAD_A, LOAD_B, START, WAIT_DONE, RD_ADDR, RD_WAIT, RD_OUT, FINISH.
REQ-012 SHALL assert cmd_ready only in IDLE; on cmd_valid&&cmd_ready, latch len_a/len_b/len_o and go to LOAD_A, or to LOAD_B if len_a=0, or to START if len_a=len_b=0.
REQ-013 SHALL assert s_ready only in LOAD_A/LOAD_B; each s_valid&&s_ready beat drives, in that same cycle, the wr_en, index and wdata of the active buffer, with wdata=s_data.
REQ-014 SHALL write indices 0..len-1 in order, using an 8-bit counter zero-extended to ADDR_W; the counter clears on every phase change.
REQ-015 SHALL leave LOAD_A after beat len_a-1, entering LOAD_B, or START if len_b=0; SHALL leave LOAD_B after beat len_b-1, entering START.
REQ-016 SHALL deassert wr_en_a/wr_en_b in every cycle without an accepted beat; index and wdata are don't-care then but SHALL hold their last value.
REQ-017 SHALL pulse tpu_start high for exactly one cycle in START, then enter WAIT_DONE.
REQ-018 SHALL ignore tpu_done in every state other than WAIT_DONE.
REQ-019 SHALL, when tpu_done=1 in WAIT_DONE, go to RD_ADDR, or to FINISH if len_o=0.
REQ-020 SHALL drive wr_en_o=0 at all times; the block never writes buffer OUT.
REQ-021 SHALL drive index_o with the read counter in RD_ADDR, go to RD_WAIT, then capture rdata_o into the m_data register at the end of RD_WAIT (one-cycle buffer read latency).
REQ-022 SHALL assert m_valid only in RD_OUT and hold m_data stable until m_ready=1.
REQ-023 SHALL, on m_valid&&m_ready, increment the read counter and go to RD_ADDR, or to FINISH after word len_o-1.
REQ-024 SHALL pulse job_done for one cycle in FINISH, then return to IDLE.
REQ-025 SHALL assert busy in every state except IDLE.
REQ-026 SHALL treat len=255 as the maximum count; the counter never wraps within a phase.

Reset
REQ-027 SHALL, while rst=0 and at any point including mid-job, force state IDLE, clear all counters and latched lengths, and drive every output to 0 except cmd_ready, which is 1 after reset release.
REQ-028 SHALL discard a job interrupted by reset; no partial stream is resumed.

Verification
REQ-029 SHALL cover: len_a=3, len_b=2, len_o=2, continuous s_valid -> A written at indices 0..2 and B at 0..1 in consecutive cycles; one tpu_start pulse; after tpu_done, m_data equals OUT[0], OUT[1] in order; one job_done pulse.
REQ-030 SHALL cover: s_valid toggling every other cycle -> wr_en follows the accepted beats only, and the index sequence has no gaps or repeats.
REQ-031 SHALL cover: m_ready held low for 5 cycles in RD_OUT -> m_valid=1 and m_data unchanged throughout; index_o does not advance.
REQ-032 SHALL cover: len_a=0, len_b=0, len_o=0 -> START follows the command with no s_ready; job_done one cycle after tpu_done.
REQ-033 SHALL cover: tpu_done pulsed during LOAD_B -> ignored, and the block still waits in WAIT_DONE for a later tpu_done.
REQ-034 SHALL cover: rst=0 asserted mid-LOAD_A with s_valid high -> wr_en_a drops immediately, busy=0, cmd_ready=1 after release; a new job then starts at index 0.
